// File: rtl/period_pkg.sv
// -----------------------------------------------------------------------------
// period_pkg
// Shared definitions for the period generator and the period meter:
//   state_t        - IDLE / RUN run-state encoding
//   N_DIV_DEFAULT  - default clocks per time unit
//   DW_DEFAULT     - default prescaler width
//   PW_DEFAULT     - default period width in time units
// -----------------------------------------------------------------------------
package period_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int N_DIV_DEFAULT = 100;
  localparam int DW_DEFAULT    = 8;
  localparam int PW_DEFAULT    = 10;

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// DW-bit down counter that reloads to N_DIV-1 and flags a tick when it reaches
// zero, giving one tick every N_DIV clocks while clr is low.
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-high reset (counter loads N_DIV-1)
//   clr   in  synchronous reload to N_DIV-1 (holds the counter while idle)
//   tick  out high while the counter is zero (combinational from the counter)
// -----------------------------------------------------------------------------
module tick_prescaler
  import period_pkg::*;
#(
  parameter int N_DIV = N_DIV_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [DW-1:0] RELOAD = DW'(N_DIV - 1);

  logic [DW-1:0] r_pre;

  // NOTE: sequential state is assigned with <= so every register samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= RELOAD;
    end else if (clr || (r_pre == '0)) begin
      r_pre <= RELOAD;
    end else begin
      r_pre <= r_pre - DW'(1);
    end
  end

  // With N_DIV=1 the reload value is zero, so tick is high every clock.
  assign tick = (r_pre == '0);

endmodule

// File: rtl/period_generator.sv
// -----------------------------------------------------------------------------
// period_generator
// Emits a one-clock NE pulse every P_cur time units (one unit = N_DIV clocks)
// plus a registered square wave. A period loaded while running is held in
// P_nxt and takes effect only on the next period boundary, so no runt periods
// are produced.
//   clk      in  system clock, rising edge
//   rst      in  asynchronous active-high reset
//   en       in  run enable (level)
//   load     in  one-cycle strobe capturing P_in
//   P_in     in  requested period in time units
//   NE       out one-clock pulse at each period boundary (registered)
//   sq       out square wave, high for the first half of each period
//   P_cur    out period currently in effect
//   pending  out a loaded period is waiting for the next boundary
// -----------------------------------------------------------------------------
module period_generator
  import period_pkg::*;
#(
  parameter int N_DIV = N_DIV_DEFAULT,
  parameter int DW    = DW_DEFAULT,
  parameter int PW    = PW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [PW-1:0] P_in,
  output logic          NE,
  output logic          sq,
  output logic [PW-1:0] P_cur,
  output logic          pending
);

  state_t        r_state, w_state_d;
  logic [PW-1:0] r_u, w_u_d;
  logic [PW-1:0] r_p_cur, w_p_cur_d;
  logic [PW-1:0] r_p_nxt, w_p_nxt_d;
  logic          r_pending, w_pending_d;
  logic          r_ne, w_ne_d;
  logic          r_sq, w_sq_d;

  logic          w_run;       // staying in RUN through this edge
  logic          w_tick;
  logic          w_boundary;
  logic [PW:0]   w_half;      // (P_cur+1)>>1, one bit wider so P_cur=max cannot wrap

  // Dropping en or running with a zero period both leave RUN on this edge.
  assign w_run = (r_state == RUN) && en && (r_p_cur != '0);

  tick_prescaler #(
    .N_DIV (N_DIV),
    .DW    (DW)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (!w_run),
    .tick (w_tick)
  );

  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_d   = r_state;
    w_u_d       = r_u;
    w_p_cur_d   = r_p_cur;
    w_p_nxt_d   = r_p_nxt;
    w_pending_d = r_pending;
    w_ne_d      = 1'b0;
    w_boundary  = 1'b0;

    case (r_state)
      IDLE: begin
        w_u_d = '0;
        if (load) begin
          w_p_cur_d   = P_in;
          w_pending_d = 1'b0;   // discard any stale P_nxt from an earlier run
        end
        if (en && (r_p_cur != '0)) begin
          w_state_d = RUN;
        end
      end

      RUN: begin
        if (!w_run) begin
          w_state_d = IDLE;
          w_u_d     = '0;
        end else if (w_tick) begin
          if (r_u == (r_p_cur - PW'(1))) begin
            w_boundary = 1'b1;
            w_ne_d     = 1'b1;
            w_u_d      = '0;
          end else begin
            w_u_d = r_u + PW'(1);
          end
        end

        // A load on the boundary cycle bypasses P_nxt and governs the very
        // next period; otherwise it waits in P_nxt (last load wins).
        if (load) begin
          if (w_boundary) begin
            w_p_cur_d   = P_in;
            w_pending_d = 1'b0;
          end else begin
            w_p_nxt_d   = P_in;
            w_pending_d = 1'b1;
          end
        end else if (w_boundary && r_pending) begin
          w_p_cur_d   = r_p_nxt;
          w_pending_d = 1'b0;
        end
      end

      default: begin
        w_state_d = IDLE;
        w_u_d     = '0;
      end
    endcase

    // sq is computed from the post-edge state so it lines up with u and with
    // a period change taking effect on the same boundary.
    w_half = ({1'b0, w_p_cur_d} + (PW+1)'(1)) >> 1;
    w_sq_d = (w_state_d == RUN) && ({1'b0, w_u_d} < w_half);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_u       <= '0;
      r_p_cur   <= '0;
      r_p_nxt   <= '0;
      r_pending <= 1'b0;
      r_ne      <= 1'b0;
      r_sq      <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_u       <= w_u_d;
      r_p_cur   <= w_p_cur_d;
      r_p_nxt   <= w_p_nxt_d;
      r_pending <= w_pending_d;
      r_ne      <= w_ne_d;
      r_sq      <= w_sq_d;
    end
  end

  assign NE      = r_ne;
  assign sq      = r_sq;
  assign P_cur   = r_p_cur;
  assign pending = r_pending;

endmodule

// File: doc/period_generator.md
Name: period_generator

Overview:
- Transmit-side counterpart of the period meter: generates a one-clock NE pulse train whose period is P time units, where one time unit = N_DIV clocks.
- Also provides a square-wave output.
- Used as a programmable stimulus and event source; its NE output connects directly to the meter's NE input.
- The period can be reprogrammed at run time. A change applies only on a period boundary, so no runt periods occur.

Parameters:
- N_DIV, 100, clocks per time unit (prescaler reload is N_DIV-1); must be >= 1.
- DW, 8, prescaler width; must satisfy 2^DW > N_DIV-1.
- PW, 10, period width in time units; matches meter P width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; level-sensitive.
- load  in  1  one-cycle strobe; captures P_in.
- P_in  in  PW  requested period in time units.
- NE  out  1  one-clock pulse at each period boundary; registered.
- sq  out  1  square wave; registered.
- P_cur  out  PW  period currently in effect.
- pending  out  1  a loaded period is waiting for the next boundary.

Behaviour:
- Reset (async, rst=1) forces:
  - NE=0, sq=0, P_cur=0, pending=0, P_nxt=0
  - state=IDLE, prescaler pre=N_DIV-1, unit counter u=0
- FSM states: IDLE, RUN. Registered state; single always_ff; next-state logic fully assigned in every branch (no latches).
- IDLE:
  - pre=N_DIV-1, u=0, NE=0, sq=0.
  - Goes to RUN on the next edge when en=1 and P_cur!=0.
- RUN:
  - pre decrements every clock. A tick occurs when pre==0; on a tick, pre reloads to N_DIV-1.
  - On a tick with u!=P_cur-1: u increments.
  - On a tick with u==P_cur-1 (boundary): u<=0, NE<=1 for exactly one cycle, and P_cur<=P_nxt if pending (pending<=0).
  - Goes to IDLE on the next edge when en=0. pre and u are reset; P_cur, P_nxt and pending are retained.
- Timing:
  - First NE is high exactly P_cur*N_DIV clocks after the edge that enters RUN.
  - Subsequent NE rising edges are spaced exactly P_cur*N_DIV clocks apart.
- sq: registered; 1 in RUN while u < (P_cur+1)>>1, otherwise 0. For P_cur=1, sq stays high throughout RUN.
- load:
  - In IDLE: P_cur<=P_in on the next edge; pending stays 0.
  - In RUN, not on a boundary cycle: P_nxt<=P_in, pending<=1. A later load overwrites P_nxt (last load wins).
  - In RUN, on a boundary cycle: P_cur<=P_in directly, pending<=0. The new value governs the immediately following period.
- P_cur==0 after a boundary update: the boundary NE still fires, then the FSM goes to IDLE. No further pulses until a nonzero load arrives.
- Reset mid-period: all counters and outputs clear asynchronously. No NE is emitted on reset release.
- Arithmetic:
  - u is PW bits and never wraps, because it is bounded by P_cur-1.
  - pre is DW bits.
  - All comparisons are unsigned.

Decomposition:
- Package period_pkg (shared with the period meter):
  - state enum {IDLE, RUN}
  - N_DIV default constant
  - PW and DW widths
- One sub-module, tick_prescaler: DW-bit down counter with reload and a tick output (pre==0).
  - Interface: clk, rst, clr, tick.
  - The period meter's n-bit down counter is to be refactored to use it later.

Test Plan:
1. Reset check: assert rst mid-stream -> NE=0, sq=0, P_cur=0, pending=0 in the same cycle; no NE for 50 clocks after release with en=1.
2. Basic period (N_DIV=4): load P_in=3 in IDLE, then en=1 -> first NE 12 clocks after entering RUN; next NEs every 12 clocks; sq high 8 clocks, low 4 clocks.
3. Mid-run load (N_DIV=4, P=3): load P_in=5 at clock 5 of a period -> pending=1 and that period still lasts 12 clocks; at the boundary P_cur=5 and pending=0; following periods last 20 clocks.
4. Boundary collision: load P_in=2 on the exact NE cycle -> next period lasts 8 clocks and pending never asserts.
5. Zero/stop (N_DIV=4, P=3): load 0 mid-run -> one more NE at the boundary, then IDLE with no pulses. Separately, dropping en mid-period -> IDLE next edge with sq=0; re-enabling gives the first NE after a full P*N_DIV clocks.
6. Minimum case (N_DIV=1, P=1) -> NE high every clock and sq constantly 1 while running.
